ls_core_mc: RTL
===============

Name: ls_core_mc

Overview:
- Parametrised multicycle successor to the single-cycle 8-bit load/store processor.
- Keeps the opcode/rd/immediate instruction layout and the sign-extended-immediate addressing.
- Adds two instructions: ADDI and BNZ (branch if not zero).
- Adds a program counter, a fetch/execute/memory state machine and variable-latency req/valid handshakes to external instruction and data memories.
- Adds retire and debug observation ports.

Parameters:
- DW, 8: data and register width.
- RA_W, 3: register-address width; register file holds 2^RA_W registers.
- IMM_W, 3: immediate width; must satisfy IMM_W <= DW and IMM_W <= PC_W.
- PC_W, 8: program-counter and instruction-address width.
- Derived localparam IW = 2+RA_W+IMM_W: instruction width. Field layout is [IW-1:IW-2] op, [IW-3:IMM_W] rd, [IMM_W-1:0] imm.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_rdata  in  IW  instruction word, valid when imem_valid=1
- imem_valid  in  1  fetch completes this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  DW  data address
- dmem_wdata  out  DW  store data
- dmem_rdata  in  DW  load data, valid when dmem_valid=1
- dmem_valid  in  1  data access completes this cycle
- retire  out  1  one-cycle pulse when an instruction completes
- retire_pc  out  PC_W  pc of the retiring instruction
- dbg_raddr  in  RA_W  debug register-read address
- dbg_rdata  out  DW  combinational rf[dbg_raddr]

Behaviour:
- Reset: one clock, synchronous and active-high. At the clk edge with reset=1:
  - state<=FETCH, pc<=0, IR<=0, all registers <=0.
  - retire<=0, retire_pc<=0.
  - After reset: imem_req=1, imem_addr=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
- Reset mid-operation: abandons any outstanding request without waiting for valid. No register or pc update happens in that cycle.
- sext(imm) = imm sign-extended to the target width (DW or PC_W). All arithmetic wraps modulo 2^width.
- Opcodes:
  - 00 LD: rd <= mem[sext(imm)].
  - 01 ST: mem[sext(imm)] <= rd.
  - 10 ADDI: rd <= rd + sext(imm).
  - 11 BNZ: pc <= (rd != 0) ? pc + sext(imm) : pc + 1.
- FETCH:
  - imem_req=1 and imem_addr=pc (combinational from state).
  - On imem_valid=1: IR<=imem_rdata, go to EXEC. Otherwise stay; pc and IR are held.
- EXEC (always one cycle):
  - ADDI: write rd, pc<=pc+1, retire, go to FETCH.
  - BNZ: update pc, retire, go to FETCH.
  - LD/ST: go to MEM.
- MEM:
  - dmem_req=1, dmem_addr=sext(imm), dmem_we=(op==01), dmem_wdata=rf[rd] (held constant while waiting).
  - On dmem_valid=1: for LD, rd<=dmem_rdata; then pc<=pc+1, retire, go to FETCH.
  - Otherwise stay with request fields stable.
- Handshake:
  - req stays high until the cycle valid=1. Valid is sampled only while req=1; valid with req=0 is ignored.
  - Zero-wait memories (valid in the same cycle as req) give CPI: ADDI/BNZ = 2, LD/ST = 3.
- retire:
  - Registered; asserted for exactly the cycle after the completing edge.
  - retire_pc = pc of the completed instruction.
- dbg_rdata reflects register writes from the following cycle onward. No write bypass.
- pc wraps from 2^PC_W-1 to 0.

Test Plan:
- Defaults, zero-wait memories, imem[0]=0x8B (ADDI r1,+3):
  - At cycle 2 after reset release: retire=1, retire_pc=0.
  - Then r1=3 and pc=1.
- Store path, r1=3, instruction 0x4E (ST r1,-2):
  - dmem_req=1, dmem_we=1, dmem_addr=0xFE, dmem_wdata=0x03 for exactly one cycle.
  - Retire 3 cycles after fetch start.
- Load path, dmem model returns 0x5A, instruction 0x16 (LD r2,-2):
  - dmem_we=0, dmem_addr=0xFE.
  - Afterwards dbg_raddr=2 gives dbg_rdata=0x5A.
- Loop, program 0x8B, 0x8F (ADDI r1,-1), 0xCF (BNZ r1,-1):
  - 7 retires with retire_pc sequence 0,1,2,1,2,1,2.
  - Final r1=0 and pc=3.
- Wait states:
  - imem_valid delayed 3 cycles: imem_req stays high and imem_addr stable; the following retire is delayed by exactly 3 cycles.
  - Same check on the dmem side for ST: dmem_addr and dmem_wdata held stable across the wait.
- Reset asserted in MEM while dmem_valid=0:
  - Next cycle: dmem_req=0, imem_req=1, imem_addr=0, all registers 0, no retire pulse.

Source files
------------

// File: rtl/ls_core_mc.sv
// ls_core_mc: multicycle load/store core with a FETCH/EXEC/MEM state machine
// and variable-latency req/valid handshakes to instruction and data memories.
module ls_core_mc #(
    parameter int DW    = 8,
    parameter int RA_W  = 3,
    parameter int IMM_W = 3,
    parameter int PC_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [PC_W-1:0]           imem_addr,
    input  logic [2+RA_W+IMM_W-1:0]   imem_rdata,
    input  logic                      imem_valid,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DW-1:0]             dmem_addr,
    output logic [DW-1:0]             dmem_wdata,
    input  logic [DW-1:0]             dmem_rdata,
    input  logic                      dmem_valid,
    output logic                      retire,
    output logic [PC_W-1:0]           retire_pc,
    input  logic [RA_W-1:0]           dbg_raddr,
    output logic [DW-1:0]             dbg_rdata
);
    localparam int IW = 2 + RA_W + IMM_W;
    localparam logic [1:0] OP_LD = 2'b00, OP_ST = 2'b01, OP_ADDI = 2'b10, OP_BNZ = 2'b11;

    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc, pc_nx;
    logic [IW-1:0]     ir;
    logic [DW-1:0]     rf [2**RA_W];
    logic [1:0]        op;
    logic [RA_W-1:0]   rd;
    logic [IMM_W-1:0]  imm;
    logic [DW-1:0]     imm_d, rd_val, wb_data;
    logic [PC_W-1:0]   imm_pc;
    logic              wb_en, done, ir_en;

    assign op        = ir[IW-1 -: 2];
    assign rd        = ir[IW-3 -: RA_W];
    assign imm       = ir[IMM_W-1:0];
    assign imm_d     = DW'($signed(imm));
    assign imm_pc    = PC_W'($signed(imm));
    assign rd_val    = rf[rd];
    assign dbg_rdata = rf[dbg_raddr];
    assign imem_addr = pc;

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        wb_en      = 1'b0;
        wb_data    = rd_val + imm_d;
        done       = 1'b0;
        ir_en      = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_en    = imem_valid;
                state_nx = imem_valid ? EXEC : FETCH;
            end
            EXEC: begin
                wb_en    = (op == OP_ADDI);
                done     = op[1];
                state_nx = op[1] ? FETCH : MEM;
                if (op[1])
                    pc_nx = (op == OP_BNZ && rd_val != '0) ? pc + imm_pc : pc + PC_W'(1);
            end
            MEM: begin
                // request fields derive only from IR and rf, so they hold while waiting
                dmem_req   = 1'b1;
                dmem_we    = (op == OP_ST);
                dmem_addr  = imm_d;
                dmem_wdata = rd_val;
                if (dmem_valid) begin
                    done     = 1'b1;
                    state_nx = FETCH;
                    pc_nx    = pc + PC_W'(1);
                    wb_en    = (op == OP_LD);
                    wb_data  = dmem_rdata;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= '0;
            ir        <= '0;
            retire    <= 1'b0;
            retire_pc <= '0;
            for (int i = 0; i < 2**RA_W; i++)
                rf[i] <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            retire <= done;
            if (ir_en)
                ir <= imem_rdata;
            if (wb_en)
                rf[rd] <= wb_data;
            if (done)
                retire_pc <= pc;
        end
    end
endmodule
